// File: rtl/prio_code_decoder_pkg.sv
// Shared types and constants for the timed one-hot code decoder.
package prio_code_decoder_pkg;

    localparam int CNT_W  = 8;
    localparam int CODE_W = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        GAP  = 2'd2
    } state_t;

endpackage

// File: rtl/prio_code_decoder_onehot_dec.sv
// Binary-to-one-hot decoder with enable; output is all zero when disabled.
module onehot_dec #(
    parameter int N_CODE = 2
) (
    input  logic                 en,
    input  logic [N_CODE-1:0]    code,
    output logic [2**N_CODE-1:0] y
);

    always_comb begin
        y = '0;
        if (en) y[code] = 1'b1;
    end

endmodule

// File: rtl/prio_code_decoder.sv
// Timed one-hot line select: holds each accepted code for a fixed time,
// inserts an idle gap, and keeps one further code in a pending buffer.
module prio_code_decoder
    import prio_code_decoder_pkg::*;
#(
    parameter int N_CODE      = CODE_W,
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [N_CODE-1:0]    in_code,
    output logic                 in_ready,
    output logic [2**N_CODE-1:0] y,
    output logic                 busy,
    output logic                 done,
    output logic [7:0]           dec_count
);

    localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LD  =
        CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_t             state, state_n;
    logic [CNT_W-1:0]   hold_cnt, hold_n;
    logic [CNT_W-1:0]   gap_cnt, gap_n;
    logic [N_CODE-1:0]  code, code_n;
    logic [N_CODE-1:0]  buf_code, buf_code_n;
    logic               buf_full, buf_full_n;
    logic               done_n;
    logic [7:0]         count_n;
    logic               accept;
    logic               serve;

    assign in_ready = !buf_full;
    assign accept   = in_valid && !buf_full;
    assign busy     = (state != IDLE);

    always_comb begin
        state_n    = state;
        hold_n     = hold_cnt;
        gap_n      = gap_cnt;
        code_n     = code;
        buf_code_n = buf_code;
        buf_full_n = buf_full;
        done_n     = 1'b0;
        count_n    = dec_count;
        serve      = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_n = HOLD;
                    code_n  = in_code;
                    hold_n  = HOLD_LD;
                end
            end
            HOLD: begin
                if (hold_cnt != '0) begin
                    hold_n = hold_cnt - CNT_W'(1);
                end else begin
                    done_n  = 1'b1;
                    count_n = dec_count + 8'd1;
                    if (GAP_CYCLES > 0) begin
                        state_n = GAP;
                        gap_n   = GAP_LD;
                    end else begin
                        serve = 1'b1;
                    end
                end
            end
            GAP: begin
                if (gap_cnt != '0) gap_n = gap_cnt - CNT_W'(1);
                else               serve = 1'b1;
            end
            default: state_n = IDLE;
        endcase
        // Buffered code wins; an empty buffer lets a same-edge accept start directly.
        if (serve) begin
            if (buf_full) begin
                state_n    = HOLD;
                code_n     = buf_code;
                hold_n     = HOLD_LD;
                buf_full_n = 1'b0;
            end else if (accept) begin
                state_n = HOLD;
                code_n  = in_code;
                hold_n  = HOLD_LD;
            end else begin
                state_n = IDLE;
            end
        end else if (accept && state != IDLE) begin
            buf_full_n = 1'b1;
            buf_code_n = in_code;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            hold_cnt  <= '0;
            gap_cnt   <= '0;
            code      <= '0;
            buf_code  <= '0;
            buf_full  <= 1'b0;
            done      <= 1'b0;
            dec_count <= 8'd0;
        end else begin
            state     <= state_n;
            hold_cnt  <= hold_n;
            gap_cnt   <= gap_n;
            code      <= code_n;
            buf_code  <= buf_code_n;
            buf_full  <= buf_full_n;
            done      <= done_n;
            dec_count <= count_n;
        end
    end

    onehot_dec #(
        .N_CODE(N_CODE)
    ) u_dec (
        .en   (state == HOLD),
        .code (code),
        .y    (y)
    );

endmodule
